pipe_cla_adder: RTL and testbench

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

---
 rtl/cla_pkg.sv | 32 +++
 rtl/cla_group4.sv | 23 ++
 rtl/pipe_cla_adder.sv | 162 ++++++++++++++++
 tb/tb_pipe_cla_adder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: group size,
// group-count helpers and the 4-bit group propagate/generate terms.
package cla_pkg;

    localparam int GROUP_W = 4;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

    function automatic int num_groups(input int width);
        return width / GROUP_W;
    endfunction

    // Second-level lookahead consumes group signals four at a time.
    function automatic int num_super_groups(input int width);
        return (num_groups(width) + GROUP_W - 1) / GROUP_W;
    endfunction

    function automatic logic group_ps(input logic [GROUP_W-1:0] p);
        return &p;
    endfunction

    function automatic logic group_gs(input logic [GROUP_W-1:0] p,
                                      input logic [GROUP_W-1:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
               (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit lookahead cell: carries c[4:1] from p/g/c0 plus group propagate and
// generate. Used both for bit carries and for carries between groups.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] p,
    input  logic [GROUP_W-1:0] g,
    input  logic               c0,
    output logic [GROUP_W:1]   c,
    output logic               ps,
    output logic               gs
);

    assign ps = group_ps(p);
    assign gs = group_gs(p, g);

    assign c[1] = g[0] | (p[0] & c0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
                  (p[2] & p[1] & p[0] & c0);
    assign c[4] = gs | (ps & c0);

endmodule

// File: rtl/pipe_cla_adder.sv
// Two-stage valid/ready adder/subtractor: stage 1 registers p/g and group
// PS/GS, stage 2 resolves carries by two-level lookahead and registers results.
module pipe_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG  = num_groups(WIDTH);
    localparam int NSG = num_super_groups(WIDTH);
    localparam int NGP = NSG * GROUP_W;

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [NG-1:0]    ps;
        logic [NG-1:0]    gs;
        logic             c0;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        flags_t           flags;
    } s2_t;

    s1_t  s1_calc, s1_d, s1_q;
    s2_t  s2_calc, s2_d, s2_q;
    logic s1_valid_d, s1_valid_q;
    logic s2_valid_d, s2_valid_q;
    logic s1_adv, s2_load, in_fire;

    // ------------------------------------------------------------ stage 1
    always_comb begin
        logic [WIDTH-1:0] b_eff;
        b_eff      = b ^ {WIDTH{sub}};
        s1_calc    = '0;
        s1_calc.p  = a ^ b_eff;
        s1_calc.g  = a & b_eff;
        s1_calc.c0 = sub | cin;
        for (int i = 0; i < NG; i++) begin
            s1_calc.ps[i] = group_ps(s1_calc.p[i*GROUP_W +: GROUP_W]);
            s1_calc.gs[i] = group_gs(s1_calc.p[i*GROUP_W +: GROUP_W],
                                     s1_calc.g[i*GROUP_W +: GROUP_W]);
        end
    end

    // ------------------------------------------------------------ stage 2
    logic [NGP-1:0]     grp_p, grp_g;
    logic [NGP:0]       gc;
    logic [WIDTH:0]     carries;
    logic [GROUP_W:1]   grp_c [NG];
    logic [NSG-1:0]     sg_ps_unused, sg_gs_unused;

    always_comb begin
        grp_p         = '0;
        grp_g         = '0;
        grp_p[NG-1:0] = s1_q.ps;
        grp_g[NG-1:0] = s1_q.gs;
    end

    assign gc[0] = s1_q.c0;

    // Second level: carry into every group from registered group PS/GS.
    for (genvar k = 0; k < NSG; k++) begin : gen_lvl2
        cla_group4 u_lvl2 (
            .p  (grp_p[k*GROUP_W +: GROUP_W]),
            .g  (grp_g[k*GROUP_W +: GROUP_W]),
            .c0 (gc[k*GROUP_W]),
            .c  (gc[k*GROUP_W+GROUP_W : k*GROUP_W+1]),
            .ps (sg_ps_unused[k]),
            .gs (sg_gs_unused[k])
        );
    end

    assign carries[0] = gc[0];

    // First level: expand each group carry-in into per-bit carries.
    for (genvar i = 0; i < NG; i++) begin : gen_grp
        logic ps_unused, gs_unused;
        cla_group4 u_grp (
            .p  (s1_q.p[i*GROUP_W +: GROUP_W]),
            .g  (s1_q.g[i*GROUP_W +: GROUP_W]),
            .c0 (gc[i]),
            .c  (grp_c[i]),
            .ps (ps_unused),
            .gs (gs_unused)
        );
        assign carries[i*GROUP_W+GROUP_W : i*GROUP_W+1] = grp_c[i];
    end

    always_comb begin
        s2_calc            = '0;
        s2_calc.sum        = s1_q.p ^ carries[WIDTH-1:0];
        s2_calc.flags.cout = gc[NG];
        s2_calc.flags.ovf  = carries[WIDTH-1] ^ carries[WIDTH];
        s2_calc.flags.zero = ~|s2_calc.sum;
    end

    // ------------------------------------------------------------ control
    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_load;
    assign in_ready = s1_adv;
    assign in_fire  = in_valid && s1_adv;

    always_comb begin
        // NOTE: hold values are assigned first so no path through this block infers a latch.
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_d = s1_calc;
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d = s2_calc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            // NOTE: data registers are cleared too, so sum and flags read 0 after reset instead of stale values.
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = s2_q.sum;
    assign cout      = s2_q.flags.cout;
    assign ovf       = s2_q.flags.ovf;
    assign zero      = s2_q.flags.zero;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Directed and randomized checks of pipe_cla_adder at WIDTH=32: arithmetic
// corner cases, back-pressure, reset flush and sustained throughput.
module tb_pipe_cla_adder;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout, ovf, zero;

    int checks = 0;
    int errors = 0;

    pipe_cla_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input logic sv);
        a        = av;
        b        = bv;
        cin      = cv;
        sub      = sv;
        in_valid = 1'b1;
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] es,
                             input logic ec, input logic eo, input logic ez);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_flags"}, {cout, ovf, zero}, {ec, eo, ez});
    endtask

    // Single op through an idle pipe: present, wait two edges, check.
    task automatic run_one(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic cv, input logic sv, input logic [W-1:0] es,
                           input logic ec, input logic eo, input logic ez);
        drive(av, bv, cv, sv);
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        check_out(tag, es, ec, eo, ez);
        tick();
    endtask

    function automatic logic [W+2:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci, input logic s);
        logic [W-1:0] ye;
        logic         c;
        logic [W:0]   t;
        logic         v;
        ye = s ? ~y : y;
        c  = s ? 1'b1 : ci;
        t  = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, c};
        v  = (x[W-1] == ye[W-1]) && (t[W-1] != x[W-1]);
        return {t[W], v, (t[W-1:0] == '0), t[W-1:0]};
    endfunction

    initial begin
        logic [W+2:0] expq [$];
        logic [W+2:0] exp_v;
        int           sent, recv, gaps, seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_sum", sum, '0);
        check("rst_flags", {cout, ovf, zero}, 3'b000);
        rst = 1'b0;
        tick();

        // Arithmetic corner cases, hand-computed.
        run_one("inc_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_one("pos_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_one("sub_5_7",    32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_one("sub_7_5",    32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        run_one("sub_cin_ig", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        run_one("add_cin",    32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
        run_one("neg_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_one("sub_equal",  32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_one("min_min",    32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        run_one("zero_cin",   32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_one("sub_zero",   32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_one("grp_chain",  32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        run_one("sg_chain",   32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h1000_0000, 1'b0, 1'b0, 1'b0);
        run_one("alt_bits",   32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // Back-pressure: three ops, out_ready low for four cycles.
        out_ready = 1'b0;
        drive(32'd1, 32'd1, 1'b0, 1'b0);
        #2;
        check("bp_rdy_first", in_ready, 1'b1);
        tick();
        drive(32'd3, 32'd4, 1'b0, 1'b0);
        #2;
        check("bp_rdy_second", in_ready, 1'b1);
        check("bp_not_yet", out_valid, 1'b0);
        tick();
        drive(32'd10, 32'd20, 1'b0, 1'b0);
        #2;
        check("bp_full_rdy", in_ready, 1'b0);
        check_out("bp_hold0", 32'd2, 1'b0, 1'b0, 1'b0);
        tick();
        #2;
        check("bp_full_rdy2", in_ready, 1'b0);
        check_out("bp_hold1", 32'd2, 1'b0, 1'b0, 1'b0);
        tick();
        out_ready = 1'b1;
        #2;
        check("bp_release_rdy", in_ready, 1'b1);
        check_out("bp_res_a", 32'd2, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        #2;
        check_out("bp_res_b", 32'd7, 1'b0, 1'b0, 1'b0);
        tick();
        #2;
        check_out("bp_res_c", 32'd30, 1'b0, 1'b0, 1'b0);
        tick();
        #2;
        check("bp_drained", out_valid, 1'b0);
        tick();

        // Reset with two ops in flight and an op presented during reset.
        out_ready = 1'b0;
        drive(32'd100, 32'd1, 1'b0, 1'b0);
        tick();
        drive(32'd200, 32'd2, 1'b0, 1'b0);
        tick();
        #2;
        check_out("rf_loaded", 32'd101, 1'b0, 1'b0, 1'b0);
        check("rf_full_rdy", in_ready, 1'b0);
        rst = 1'b1;
        drive(32'd300, 32'd3, 1'b0, 1'b0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #2;
        check("rf_out_valid", out_valid, 1'b0);
        check("rf_in_ready", in_ready, 1'b1);
        check("rf_sum", sum, '0);
        out_ready = 1'b1;
        seen      = 0;
        repeat (5) begin
            tick();
            #2;
            if (out_valid) seen++;
        end
        check("rf_no_emit", seen, 0);
        tick();

        // Randomized stream at full throughput against the reference model.
        sent = 0;
        recv = 0;
        gaps = 0;
        for (int cyc = 0; cyc < 1100; cyc++) begin
            if (sent < 1000) begin
                drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                in_valid = 1'b0;
            end
            #2;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    check("rnd_unexpected", out_valid, 1'b0);
                end else begin
                    exp_v = expq.pop_front();
                    check("rnd_result", {cout, ovf, zero, sum}, exp_v);
                    recv++;
                end
            end else if (recv > 0 && (expq.size() > 0 || sent < 1000)) begin
                gaps++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(ref_add(a, b, cin, sub));
                sent++;
            end
            tick();
        end
        check("rnd_count", recv, 1000);
        check("rnd_gaps", gaps, 0);
        check("rnd_leftover", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
